// File: rtl/rvvi_retire_scheduler.sv
// Per-hart retire FIFOs merged round-robin into one registered output event stream.
// Optional order-gap checker enabled by defining RVVI_ORDER_CHECK_EN.
module rvvi_retire_scheduler #(
  parameter int unsigned NHART  = 1,
  parameter int unsigned RETIRE = 1,
  parameter int unsigned PW     = 96,
  parameter int unsigned DEPTH  = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NHART*RETIRE-1:0]      in_valid,
  input  logic [NHART*RETIRE*64-1:0]   in_order,
  input  logic [NHART*RETIRE*PW-1:0]   in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [$clog2(NHART):0]       out_hart,
  output logic [63:0]                  out_order,
  output logic [PW-1:0]                out_data,
  output logic [NHART-1:0]             overflow,
  output logic [NHART-1:0]             order_err
);

  localparam int unsigned AW   = $clog2(DEPTH);
  localparam int unsigned PTRW = AW + 1;
  localparam int unsigned HW   = $clog2(NHART) + 1;
  localparam int unsigned EW   = 64 + PW;

  logic [EW-1:0]   mem_q    [NHART][DEPTH];
  logic [PTRW-1:0] wr_ptr_q [NHART];
  logic [PTRW-1:0] wr_ptr_d [NHART];
  logic [PTRW-1:0] rd_ptr_q [NHART];
  logic [PTRW-1:0] rd_ptr_d [NHART];
  logic [PTRW-1:0] used     [NHART];
  logic [PTRW-1:0] nvalid   [NHART];
  logic [PTRW-1:0] slot_pos [NHART][RETIRE];
  logic [NHART-1:0] accept, empty, pop;
  logic [NHART-1:0] overflow_q, overflow_d;

  logic            out_valid_q;
  logic [HW-1:0]   out_hart_q;
  logic [63:0]     out_order_q;
  logic [PW-1:0]   out_data_q;
  logic [HW-1:0]   rr_q;

  logic            load_en;
  logic            gnt_valid;
  int unsigned     gnt_h;
  logic [EW-1:0]   head;

  // Free space is judged on pre-pop occupancy; valid slots are packed densely in slot order.
  always_comb begin
    for (int unsigned h = 0; h < NHART; h++) begin
      used[h]   = wr_ptr_q[h] - rd_ptr_q[h];
      empty[h]  = (used[h] == '0);
      nvalid[h] = '0;
      for (int unsigned s = 0; s < RETIRE; s++) begin
        slot_pos[h][s] = wr_ptr_q[h] + nvalid[h];
        if (in_valid[h*RETIRE+s]) nvalid[h] = nvalid[h] + PTRW'(1);
      end
      accept[h]     = (nvalid[h] <= (PTRW'(DEPTH) - used[h]));
      wr_ptr_d[h]   = accept[h] ? (wr_ptr_q[h] + nvalid[h]) : wr_ptr_q[h];
      overflow_d[h] = overflow_q[h] | ~accept[h];
    end
  end

  // Two passes give "first non-empty at or after rr" with wrap-around.
  always_comb begin
    load_en   = !out_valid_q || out_ready;
    gnt_valid = 1'b0;
    gnt_h     = 0;
    for (int unsigned h = 0; h < NHART; h++) begin
      if (!gnt_valid && (h >= 32'(rr_q)) && !empty[h]) begin
        gnt_valid = 1'b1;
        gnt_h     = h;
      end
    end
    for (int unsigned h = 0; h < NHART; h++) begin
      if (!gnt_valid && !empty[h]) begin
        gnt_valid = 1'b1;
        gnt_h     = h;
      end
    end
  end

  always_comb begin
    head = '0;
    for (int unsigned h = 0; h < NHART; h++) begin
      pop[h]      = load_en && gnt_valid && (gnt_h == h);
      rd_ptr_d[h] = rd_ptr_q[h] + {{(PTRW-1){1'b0}}, pop[h]};
      if (gnt_valid && (gnt_h == h)) head = mem_q[h][rd_ptr_q[h][AW-1:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned h = 0; h < NHART; h++) begin
        wr_ptr_q[h] <= '0;
        rd_ptr_q[h] <= '0;
      end
      overflow_q <= '0;
    end else begin
      for (int unsigned h = 0; h < NHART; h++) begin
        wr_ptr_q[h] <= wr_ptr_d[h];
        rd_ptr_q[h] <= rd_ptr_d[h];
      end
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int unsigned h = 0; h < NHART; h++) begin
        for (int unsigned s = 0; s < RETIRE; s++) begin
          if (accept[h] && in_valid[h*RETIRE+s])
            mem_q[h][slot_pos[h][s][AW-1:0]] <= {in_order[(h*RETIRE+s)*64 +: 64],
                                                 in_data[(h*RETIRE+s)*PW +: PW]};
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_hart_q  <= '0;
      out_order_q <= '0;
      out_data_q  <= '0;
      rr_q        <= '0;
    end else if (load_en) begin
      out_valid_q <= gnt_valid;
      if (gnt_valid) begin
        out_hart_q                <= HW'(gnt_h);
        {out_order_q, out_data_q} <= head;
        rr_q                      <= (gnt_h == NHART - 1) ? '0 : HW'(gnt_h + 1);
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_hart  = out_hart_q;
  assign out_order = out_order_q;
  assign out_data  = out_data_q;
  assign overflow  = overflow_q;

`ifdef RVVI_ORDER_CHECK_EN
  logic [63:0]      exp_q [NHART];
  logic [NHART-1:0] seen_q, err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned h = 0; h < NHART; h++) exp_q[h] <= '0;
      seen_q <= '0;
      err_q  <= '0;
    end else if (out_valid_q && out_ready) begin
      for (int unsigned h = 0; h < NHART; h++) begin
        if (32'(out_hart_q) == h) begin
          if (seen_q[h] && (out_order_q != exp_q[h] + 64'd1)) err_q[h] <= 1'b1;
          exp_q[h]  <= out_order_q;
          seen_q[h] <= 1'b1;
        end
      end
    end
  end

  assign order_err = err_q;
`else
  assign order_err = '0;
`endif

endmodule

// File: tb/tb_rvvi_retire_scheduler.sv
// Directed bench for rvvi_retire_scheduler with NHART=2, RETIRE=2, DEPTH=4, PW=32.
module tb_rvvi_retire_scheduler;
  localparam int NH = 2;
  localparam int RT = 2;
  localparam int PWT = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic [NH*RT-1:0]  in_valid;
  logic [NH*RT*64-1:0] in_order;
  logic [NH*RT*PWT-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [1:0]        out_hart;
  logic [63:0]       out_order;
  logic [PWT-1:0]    out_data;
  logic [NH-1:0]     overflow;
  logic [NH-1:0]     order_err;

  int checks = 0;
  int errors = 0;

  rvvi_retire_scheduler #(.NHART(NH), .RETIRE(RT), .PW(PWT), .DEPTH(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_order(in_order), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_hart(out_hart), .out_order(out_order),
    .out_data(out_data), .overflow(overflow), .order_err(order_err)
  );

  always #5 clk = ~clk;

  function automatic logic [PWT-1:0] dat(input logic [63:0] o);
    return 32'hC0DE_0000 ^ o[31:0];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    in_valid = '0;
    in_order = '0;
    in_data  = '0;
  endtask

  task automatic put(input int idx, input logic [63:0] o);
    in_valid[idx] = 1'b1;
    in_order[idx*64 +: 64] = o;
    in_data[idx*PWT +: PWT] = dat(o);
  endtask

  task automatic do_reset();
    clear_in();
    out_ready = 1'b0;
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (out_valid !== 1'b0 || out_hart !== 2'd0 || out_order !== 64'd0 || out_data !== '0) begin
      errors++;
      $display("FAIL reset_out: valid=%0b hart=%0d order=%0d data=%h, want all 0", out_valid, out_hart, out_order, out_data);
    end
    checks++;
    if (overflow !== 2'b00 || order_err !== 2'b00) begin
      errors++;
      $display("FAIL reset_flags: overflow=%b order_err=%b, want 00 00", overflow, order_err);
    end
  endtask

  task automatic test_interleave();
    logic [1:0]  eh [3] = '{2'd0, 2'd1, 2'd0};
    logic [63:0] eo [3] = '{64'd5, 64'd9, 64'd6};
    do_reset();
    out_ready = 1'b1;
    put(0, 64'd5); put(1, 64'd6); put(2, 64'd9);
    step();
    clear_in();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL latency_early: out_valid=%0b one edge after input, want 0", out_valid);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (out_valid !== 1'b1 || out_hart !== eh[i] || out_order !== eo[i] || out_data !== dat(eo[i])) begin
        errors++;
        $display("FAIL interleave[%0d]: valid=%0b hart=%0d order=%0d data=%h, want 1 %0d %0d %h",
                 i, out_valid, out_hart, out_order, out_data, eh[i], eo[i], dat(eo[i]));
      end
    end
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL interleave_drain: out_valid=%0b, want 0", out_valid);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    put(0, 64'd1); put(1, 64'd2); step();
    put(0, 64'd3); put(1, 64'd4); step();
    checks++;
    if (overflow !== 2'b00) begin
      errors++;
      $display("FAIL overflow_early: overflow=%b, want 00", overflow);
    end
    put(0, 64'd5); put(1, 64'd6); step();
    clear_in();
    checks++;
    if (overflow !== 2'b01) begin
      errors++;
      $display("FAIL overflow_set: overflow=%b, want 01", overflow);
    end
    checks++;
    if (out_valid !== 1'b1 || out_order !== 64'd1) begin
      errors++;
      $display("FAIL overflow_head: valid=%0b order=%0d, want 1 1", out_valid, out_order);
    end
    out_ready = 1'b1;
    for (int i = 2; i <= 4; i++) begin
      step();
      checks++;
      if (out_valid !== 1'b1 || out_hart !== 2'd0 || out_order !== 64'(i) || out_data !== dat(64'(i))) begin
        errors++;
        $display("FAIL overflow_drain[%0d]: valid=%0b hart=%0d order=%0d, want 1 0 %0d", i, out_valid, out_hart, out_order, i);
      end
    end
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL overflow_nostale: valid=%0b order=%0d, want valid 0", out_valid, out_order);
    end
  endtask

  task automatic test_full_pushpop();
    do_reset();
    put(2, 64'd10); put(3, 64'd11); step();
    put(2, 64'd12); put(3, 64'd13); step();
    clear_in();
    put(2, 64'd14); step();
    checks++;
    if (overflow !== 2'b00) begin
      errors++;
      $display("FAIL full_fill: overflow=%b, want 00", overflow);
    end
    clear_in();
    put(2, 64'd15);
    out_ready = 1'b1;
    step();
    clear_in();
    checks++;
    if (overflow !== 2'b10 || out_valid !== 1'b1 || out_hart !== 2'd1 || out_order !== 64'd11) begin
      errors++;
      $display("FAIL full_pushpop: overflow=%b valid=%0b hart=%0d order=%0d, want 10 1 1 11",
               overflow, out_valid, out_hart, out_order);
    end
    for (int i = 12; i <= 14; i++) begin
      step();
      checks++;
      if (out_valid !== 1'b1 || out_hart !== 2'd1 || out_order !== 64'(i)) begin
        errors++;
        $display("FAIL full_drain[%0d]: valid=%0b hart=%0d order=%0d, want 1 1 %0d", i, out_valid, out_hart, out_order, i);
      end
    end
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL full_rejected: valid=%0b order=%0d, want valid 0", out_valid, out_order);
    end
  endtask

  task automatic test_hold();
    do_reset();
    put(0, 64'd20); put(1, 64'd21); step();
    clear_in();
    step();
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (out_valid !== 1'b1 || out_order !== 64'd20 || out_data !== dat(64'd20)) begin
        errors++;
        $display("FAIL hold[%0d]: valid=%0b order=%0d data=%h, want 1 20 %h", i, out_valid, out_order, out_data, dat(64'd20));
      end
    end
    out_ready = 1'b1;
    step();
    checks++;
    if (out_valid !== 1'b1 || out_order !== 64'd21 || out_data !== dat(64'd21)) begin
      errors++;
      $display("FAIL hold_release: valid=%0b order=%0d, want 1 21", out_valid, out_order);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    put(0, 64'd30); put(1, 64'd31); step();
    put(0, 64'd32); put(1, 64'd33); step();
    put(0, 64'd34); put(1, 64'd35); step();
    clear_in();
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || overflow !== 2'b00) begin
      errors++;
      $display("FAIL reset_mid: valid=%0b overflow=%b, want 0 00", out_valid, overflow);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL reset_stale[%0d]: valid=%0b order=%0d, want valid 0", i, out_valid, out_order);
      end
    end
    put(2, 64'd40); step();
    clear_in();
    step();
    checks++;
    if (out_valid !== 1'b1 || out_hart !== 2'd1 || out_order !== 64'd40) begin
      errors++;
      $display("FAIL reset_resume: valid=%0b hart=%0d order=%0d, want 1 1 40", out_valid, out_hart, out_order);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0]  eh;
    logic [63:0] eo;
    do_reset();
    out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      clear_in();
      put(0, 64'(100 + 2*c));
      put(2, 64'(101 + 2*c));
      step();
      if (c > 0) begin
        eh = 2'((c-1) % 2);
        eo = 64'(100 + 2*((c-1)/2) + (c-1) % 2);
        checks++;
        if (out_valid !== 1'b1 || out_hart !== eh || out_order !== eo) begin
          errors++;
          $display("FAIL fair[%0d]: valid=%0b hart=%0d order=%0d, want 1 %0d %0d", c-1, out_valid, out_hart, out_order, eh, eo);
        end
      end
    end
    clear_in();
    for (int k = 5; k < 12; k++) begin
      step();
      eh = 2'(k % 2);
      eo = 64'(100 + 2*(k/2) + k % 2);
      checks++;
      if (out_valid !== 1'b1 || out_hart !== eh || out_order !== eo) begin
        errors++;
        $display("FAIL fair[%0d]: valid=%0b hart=%0d order=%0d, want 1 %0d %0d", k, out_valid, out_hart, out_order, eh, eo);
      end
    end
    step();
    checks++;
    if (out_valid !== 1'b0 || overflow !== 2'b00 || order_err !== 2'b00) begin
      errors++;
      $display("FAIL fair_end: valid=%0b overflow=%b order_err=%b, want 0 00 00", out_valid, overflow, order_err);
    end
  endtask

`ifdef RVVI_ORDER_CHECK_EN
  task automatic test_order_check();
    logic [63:0] seqs [2][3] = '{'{64'd1, 64'd2, 64'd4}, '{64'd1, 64'd2, 64'd3}};
    logic [1:0]  want [2] = '{2'b01, 2'b00};
    for (int t = 0; t < 2; t++) begin
      do_reset();
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
        clear_in();
        put(0, seqs[t][i]);
        step();
      end
      clear_in();
      for (int i = 0; i < 4; i++) step();
      checks++;
      if (order_err !== want[t]) begin
        errors++;
        $display("FAIL order_check[%0d]: order_err=%b, want %b", t, order_err, want[t]);
      end
    end
  endtask
`endif

  initial begin
    clear_in();
    out_ready = 1'b0;
    reset = 1'b1;
    test_reset();
    test_interleave();
    test_overflow();
    test_full_pushpop();
    test_hold();
    test_reset_mid();
    test_back_to_back();
`ifdef RVVI_ORDER_CHECK_EN
    test_order_check();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
